id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage that registers one decoded instruction per cycle and drives the ALU's `a`, `b` and `op2` inputs. It resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and inserts a one-cycle bubble on a load-use dependency. It sits between the register-file/decode stage and the ALU, with a valid/ready handshake on the decode side and a ready-based stall from downstream.

## Interface
- `DW`, 32, datapath width
- `RW`, 5, register-address width

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode presents an instruction.
- `id_ready` out 1: stage accepts the decode instruction this cycle.
- `id_rs`, `id_rt`, `id_rd` in RW: source and destination register addresses.
- `id_rd1`, `id_rd2` in DW: register-file read data for rs and rt.
- `id_imm` in DW: sign-extended immediate.
- `id_alusrc` in 1: when 1, ALU `b` takes the immediate.
- `id_op2` in 3: ALU op (0 AND, 1 OR, 2 SUB, 3 MUL, 4 DIV, 5 ADD, 6 SLT, 7 NOP).
- `id_regwrite`, `id_memread` in 1: writeback enable and load flag.
- `flush` in 1: discard the held instruction and any incoming one.
- `ex_ready` in 1: downstream accepts the current EX instruction.
- `exm_regwrite` in 1, `exm_rd` in RW, `exm_result` in DW: EX/MEM forwarding source.
- `wb_regwrite` in 1, `wb_rd` in RW, `wb_data` in DW: MEM/WB forwarding source.
- `alu_a`, `alu_b` out DW: ALU operands.
- `alu_op2` out 3: ALU op.
- `ex_valid` out 1: stage holds a live instruction.
- `ex_rd` out RW, `ex_regwrite` out 1, `ex_memread` out 1: pass-through control.
- `ex_store_data` out DW: forwarded rt value, for stores.

## Operation

**State register.** Holds `valid`, rs, rt, rd, rd1, rd2, imm, alusrc, op2, regwrite and memread.

**Hazard signal.**
- `hazard` = `valid` & `memread` & `regwrite` & (rd≠0) & `id_valid` & ((`id_rs`==rd) | (`id_rt`==rd)).
- `id_ready` = `flush` | (`ex_ready` & ~`hazard`).

**Update priority per clock edge:**
1. `flush`: `valid`←0. Incoming instruction is consumed and dropped.
2. ~`ex_ready`: all state held. Forwarding outputs still re-evaluate.
3. `hazard`: `valid`←0 (bubble). Decode is held because `id_ready`=0.
4. Otherwise load all fields from decode, with `valid`←`id_valid`.

**Capture bypass.** When loading, if `wb_regwrite` & (`wb_rd`≠0) & (`wb_rd`==`id_rs`), capture `wb_data` in place of `id_rd1`. The same rule applies to rt/`id_rd2`.

**Forwarding (combinational from registered rs/rt).**
- For each operand, in priority order:
  1. If `exm_regwrite` & (`exm_rd`≠0) & (`exm_rd`==reg), select `exm_result`.
  2. Else if `wb_regwrite` & (`wb_rd`≠0) & (`wb_rd`==reg), select `wb_data`.
  3. Else select the registered value.
- `alu_a` = fwd(rs).
- `ex_store_data` = fwd(rt).
- `alu_b` = `alusrc` ? imm : fwd(rt).

**Bubble outputs.** When `valid`=0: `alu_op2`=7, `alu_a`=`alu_b`=0, `ex_regwrite`=0, `ex_memread`=0.

## Timing
- Reset (async assert, sync-safe release) sets all state registers to 0, `valid`=0, and op2 to 7. Resulting outputs: `alu_a`=0, `alu_b`=0, `alu_op2`=7, `ex_valid`=0, `ex_rd`=0, `ex_regwrite`=0, `ex_memread`=0, `ex_store_data`=0, `id_ready`=`ex_ready`.
- Latency: 1 cycle from the `id_valid`&`id_ready` edge to operands on the ALU.
- Forwarding muxes are same-cycle combinational. There is no added latency.
- Load-use: exactly one bubble, then the dependent instruction loads. Its operand is forwarded from EX/MEM (if still there) or MEM/WB.
- Reset mid-stall or mid-hazard: the instruction is lost and the stage returns to reset values immediately.
- `flush` together with `hazard`: flush wins, and `id_ready`=1.
- `flush` together with ~`ex_ready`: flush wins.
- Register 0 is never forwarded, stalled on, or bypassed.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-cycle → all outputs go to reset values asynchronously; `alu_op2`=7.
- **Plain issue.** ADD with rs=1 (rd1=5), rt=2 (rd2=7), no forwarding → next cycle `alu_a`=5, `alu_b`=7, `alu_op2`=5, `ex_valid`=1.
- **Forwarding priority.** EX/MEM writes r3=0x10 and MEM/WB writes r3=0x20; EX instruction has rs=3 → `alu_a`=0x10. Drop `exm_regwrite` → `alu_a`=0x20.
- **Load-use.** Load to r4 in EX, then decode rs=4 → `id_ready`=0 for one cycle and `ex_valid`=0 the next cycle. Dependent instruction loads the following cycle, with `alu_a`=`wb_data` when the load is in WB.
- **Stall and flush.** `ex_ready`=0 for 3 cycles → outputs stable and `id_ready`=0. `flush` pulse during the stall → `ex_valid`=0 next cycle.
- **Zero register and immediate.** `exm_rd`=0 with `exm_regwrite`=1 and rs=0 → no forwarding. With `alusrc`=1 and imm=0xFFFFFFFC → `alu_b`=0xFFFFFFFC and `ex_store_data`=fwd(rt).

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding, load-use bubble and flush.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic          id_alusrc,
    input  logic [2:0]    id_op2,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          flush,
    input  logic          ex_ready,
    input  logic          exm_regwrite,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op2,
    output logic          ex_valid,
    output logic [RW-1:0] ex_rd,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic [DW-1:0] ex_store_data
);
    logic          valid_q, valid_d, alusrc_q, regwrite_q, memread_q, hazard, load;
    logic [RW-1:0] rs_q, rt_q, rd_q;
    logic [DW-1:0] rd1_q, rd2_q, rd1_d, rd2_d, imm_q, fwd_a, fwd_b;
    logic [2:0]    op2_q;

    function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r, input logic [DW-1:0] v);
        return (exm_regwrite && exm_rd != '0 && exm_rd == r) ? exm_result :
               (wb_regwrite && wb_rd != '0 && wb_rd == r) ? wb_data : v;
    endfunction

    always_comb begin
        hazard  = valid_q & memread_q & regwrite_q & (rd_q != '0) & id_valid &
                  ((id_rs == rd_q) | (id_rt == rd_q));
        id_ready = flush | (ex_ready & ~hazard);
        load    = ~flush & ex_ready & ~hazard;
        valid_d = flush ? 1'b0 : !ex_ready ? valid_q : hazard ? 1'b0 : id_valid;
        // The register file may not yet hold a value being written back this cycle.
        rd1_d   = (wb_regwrite && wb_rd != '0 && wb_rd == id_rs) ? wb_data : id_rd1;
        rd2_d   = (wb_regwrite && wb_rd != '0 && wb_rd == id_rt) ? wb_data : id_rd2;
        fwd_a   = fwd(rs_q, rd1_q);
        fwd_b   = fwd(rt_q, rd2_q);
        alu_a         = valid_q ? fwd_a : '0;
        alu_b         = valid_q ? (alusrc_q ? imm_q : fwd_b) : '0;
        alu_op2       = valid_q ? op2_q : 3'd7;
        ex_valid      = valid_q;
        ex_rd         = rd_q;
        ex_regwrite   = valid_q & regwrite_q;
        ex_memread    = valid_q & memread_q;
        ex_store_data = fwd_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            alusrc_q   <= 1'b0;
            op2_q      <= 3'd7;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                rs_q       <= id_rs;
                rt_q       <= id_rt;
                rd_q       <= id_rd;
                rd1_q      <= rd1_d;
                rd2_q      <= rd2_d;
                imm_q      <= id_imm;
                alusrc_q   <= id_alusrc;
                op2_q      <= id_op2;
                regwrite_q <= id_regwrite;
                memread_q  <= id_memread;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [31:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
    logic        id_alusrc = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
    logic [2:0]  id_op2 = 3'd7;
    logic        flush = 1'b0, ex_ready = 1'b1;
    logic        exm_regwrite = 1'b0, wb_regwrite = 1'b0;
    logic [4:0]  exm_rd = '0, wb_rd = '0;
    logic [31:0] exm_result = '0, wb_data = '0;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_op2;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    int total = 0, bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_op2(id_op2),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .ex_ready(ex_ready), .exm_regwrite(exm_regwrite), .exm_rd(exm_rd),
        .exm_result(exm_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op2(alu_op2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2, imm,
                         input logic als, input logic [2:0] op, input logic rw, mr);
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_rd1 = d1; id_rd2 = d2;
        id_imm = imm; id_alusrc = als; id_op2 = op; id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    initial begin
        #2;
        check("rst_op2", alu_op2, 7);
        check("rst_valid", ex_valid, 0);
        check("rst_a", alu_a, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_ready", id_ready, 1);
        #10 rst_n = 1'b1;
        tick();
        // plain issue
        issue(1, 2, 6, 5, 7, 0, 0, 5, 1, 0);
        check("plain_ready", id_ready, 1);
        tick();
        id_valid = 1'b0;
        check("plain_a", alu_a, 5);
        check("plain_b", alu_b, 7);
        check("plain_op", alu_op2, 5);
        check("plain_valid", ex_valid, 1);
        check("plain_rd", ex_rd, 6);
        check("plain_rw", ex_regwrite, 1);
        check("plain_store", ex_store_data, 7);
        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_op", alu_op2, 7);
        check("arst_a", alu_a, 0);
        check("arst_rd", ex_rd, 0);
        check("arst_rw", ex_regwrite, 0);
        #1 rst_n = 1'b1;
        tick();
        // forwarding priority
        issue(3, 0, 7, 32'h99, 0, 0, 0, 5, 1, 0);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        exm_regwrite = 1; exm_rd = 3; exm_result = 32'h10;
        wb_regwrite = 1; wb_rd = 3; wb_data = 32'h20;
        #1;
        check("fwd_exm", alu_a, 32'h10);
        check("stall_ready", id_ready, 0);
        exm_regwrite = 0; #1;
        check("fwd_wb", alu_a, 32'h20);
        wb_regwrite = 0; #1;
        check("fwd_none", alu_a, 32'h99);
        // capture bypass from WB at load time
        ex_ready = 1'b1;
        issue(8, 9, 10, 1, 2, 0, 0, 5, 1, 0);
        wb_regwrite = 1; wb_rd = 9; wb_data = 32'h55;
        tick();
        id_valid = 1'b0; ex_ready = 1'b0; wb_regwrite = 0; #1;
        check("byp_a", alu_a, 1);
        check("byp_b", alu_b, 32'h55);
        // load-use
        ex_ready = 1'b1;
        issue(1, 0, 4, 32'h100, 0, 8, 1, 5, 1, 1);
        tick();
        check("ld_mr", ex_memread, 1);
        check("ld_b", alu_b, 8);
        issue(4, 2, 5, 32'hDEAD, 3, 0, 0, 2, 1, 0);
        check("lu_ready", id_ready, 0);
        tick();
        check("bub_valid", ex_valid, 0);
        check("bub_op", alu_op2, 7);
        check("bub_a", alu_a, 0);
        check("bub_mr", ex_memread, 0);
        check("bub_rw", ex_regwrite, 0);
        check("bub_ready", id_ready, 1);
        tick();
        id_valid = 1'b0; ex_ready = 1'b0;
        wb_regwrite = 1; wb_rd = 4; wb_data = 32'h777; #1;
        check("dep_a", alu_a, 32'h777);
        check("dep_b", alu_b, 3);
        check("dep_op", alu_op2, 2);
        check("dep_valid", ex_valid, 1);
        wb_regwrite = 0;
        // stall then flush
        ex_ready = 1'b1;
        issue(10, 11, 12, 32'hA, 32'hB, 0, 0, 0, 1, 0);
        tick();
        ex_ready = 1'b0;
        issue(13, 14, 15, 32'hC, 32'hD, 0, 0, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check("stl_ready", id_ready, 0);
            check("stl_a", alu_a, 32'hA);
            check("stl_b", alu_b, 32'hB);
            check("stl_op", alu_op2, 0);
            check("stl_valid", ex_valid, 1);
            tick();
        end
        flush = 1'b1; #1;
        check("fl_ready", id_ready, 1);
        tick();
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1; #1;
        check("fl_valid", ex_valid, 0);
        check("fl_op", alu_op2, 7);
        // flush wins over hazard
        issue(1, 0, 4, 0, 0, 0, 1, 5, 1, 1);
        tick();
        issue(4, 0, 5, 0, 0, 0, 0, 5, 1, 0);
        check("hz_ready", id_ready, 0);
        flush = 1'b1; #1;
        check("flhz_ready", id_ready, 1);
        tick();
        flush = 1'b0; id_valid = 1'b0; #1;
        check("flhz_valid", ex_valid, 0);
        // zero register and immediate
        issue(0, 2, 1, 0, 32'h33, 32'hFFFFFFFC, 1, 5, 1, 0);
        wb_regwrite = 1; wb_rd = 0; wb_data = 32'hBAD;
        tick();
        id_valid = 1'b0; ex_ready = 1'b0; wb_regwrite = 0;
        exm_regwrite = 1; exm_rd = 0; exm_result = 32'h1234; #1;
        check("z_a", alu_a, 0);
        check("z_b", alu_b, 32'hFFFFFFFC);
        check("z_store", ex_store_data, 32'h33);
        exm_rd = 2; exm_result = 32'h44; #1;
        check("imm_b", alu_b, 32'hFFFFFFFC);
        check("imm_store", ex_store_data, 32'h44);
        exm_regwrite = 0; ex_ready = 1'b1;
        // load to r0 never stalls
        issue(1, 0, 0, 0, 0, 0, 1, 5, 1, 1);
        tick();
        issue(0, 0, 5, 0, 0, 0, 0, 5, 1, 0);
        check("z_lu_ready", id_ready, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
